// File: rtl/bcd_display_scan.sv
// bcd_display_scan: 4-digit multiplexed seven-segment driver for packed BCD.
// A loaded word is held pending and only becomes visible at a frame boundary,
// so a digit pattern from two different words is never shown within one frame.

`timescale 1ns/1ps

module bcd_display_scan #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] bcd_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam int unsigned PcW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PcW-1:0] PcLast = PcW'(PRESCALE - 1);

  // Segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] Seg0    = 7'h3F;
  localparam logic [6:0] Seg1    = 7'h06;
  localparam logic [6:0] Seg2    = 7'h5B;
  localparam logic [6:0] Seg3    = 7'h4F;
  localparam logic [6:0] Seg4    = 7'h66;
  localparam logic [6:0] Seg5    = 7'h6D;
  localparam logic [6:0] Seg6    = 7'h7D;
  localparam logic [6:0] Seg7    = 7'h07;
  localparam logic [6:0] Seg8    = 7'h7F;
  localparam logic [6:0] Seg9    = 7'h6F;
  localparam logic [6:0] SegDash = 7'h40;

  logic [PcW-1:0] pc_q, pc_d;
  logic [1:0]     idx_q, idx_d;
  logic [15:0]    act_q, act_d;
  logic [15:0]    pnd_q, pnd_d;
  logic           pf_q, pf_d;
  logic           fd_q, fd_d;

  logic           tick;
  logic           boundary;

  logic [3:0]     cur_digit;
  logic [6:0]     seg_raw;
  logic [3:0]     zero_from;
  logic [3:0]     blank_vec;
  logic           blanked;

  assign tick     = (pc_q == PcLast);
  assign boundary = tick && (idx_q == 2'd3);

  // Next-state: prescaler, digit scan, pending/active word handoff
  always_comb begin
    pc_d  = pc_q;
    idx_d = idx_q;
    act_d = act_q;
    pnd_d = pnd_q;
    pf_d  = pf_q;
    fd_d  = 1'b0;

    if (tick) begin
      pc_d  = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      pc_d  = pc_q + PcW'(1);
    end

    // Commit happens before the load below so a coincident load stays pending
    if (boundary) begin
      fd_d = 1'b1;
      if (pf_q) begin
        act_d = pnd_q;
        pf_d  = 1'b0;
      end
    end

    if (load) begin
      pnd_d = bcd_in;
      pf_d  = 1'b1;
    end
  end

  // State register with synchronous clear; clear discards pending data
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q  <= '0;
      idx_q <= 2'd0;
      act_q <= 16'h0000;
      pnd_q <= 16'h0000;
      pf_q  <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      idx_q <= idx_d;
      act_q <= act_d;
      pnd_q <= pnd_d;
      pf_q  <= pf_d;
      fd_q  <= fd_d;
    end
  end

  // Select the nibble of the active word for the scanned digit
  always_comb begin
    cur_digit = act_q[3:0];
    unique case (idx_q)
      2'd0: cur_digit = act_q[3:0];
      2'd1: cur_digit = act_q[7:4];
      2'd2: cur_digit = act_q[11:8];
      2'd3: cur_digit = act_q[15:12];
      default: cur_digit = act_q[3:0];
    endcase
  end

  // BCD to segment decode; codes 10-15 show a dash
  always_comb begin
    seg_raw = SegDash;
    case (cur_digit)
      4'd0: seg_raw = Seg0;
      4'd1: seg_raw = Seg1;
      4'd2: seg_raw = Seg2;
      4'd3: seg_raw = Seg3;
      4'd4: seg_raw = Seg4;
      4'd5: seg_raw = Seg5;
      4'd6: seg_raw = Seg6;
      4'd7: seg_raw = Seg7;
      4'd8: seg_raw = Seg8;
      4'd9: seg_raw = Seg9;
      default: seg_raw = SegDash;
    endcase
  end

  // zero_from[i]: digit i and all more-significant digits are zero.
  // Digit 0 is excluded from the blanking mask so a value of zero still shows.
  always_comb begin
    zero_from    = 4'b0000;
    zero_from[3] = (act_q[15:12] == 4'd0);
    zero_from[2] = zero_from[3] && (act_q[11:8] == 4'd0);
    zero_from[1] = zero_from[2] && (act_q[7:4] == 4'd0);
    zero_from[0] = zero_from[1] && (act_q[3:0] == 4'd0);
    blank_vec    = {zero_from[3:1], 1'b0} & {4{blank_lz}};
    blanked      = blank_vec[idx_q];
  end

  // Output decode; blanked digits drive neither segments nor anode
  always_comb begin
    seg = seg_raw;
    an  = 4'b0001 << idx_q;
    if (blanked) begin
      seg = 7'h00;
      an  = 4'b0000;
    end
  end

  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan: directed vector table, multi-cycle
// load/clear sequences, and randomized traffic against a frame-level model.

`timescale 1ns/1ps

module tb_bcd_display_scan;

  localparam int unsigned P = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: edges counted since clear, plus displayed/pending words
  int unsigned n_edges = 0;
  logic [15:0] m_act = 16'h0000;
  logic [15:0] m_pnd = 16'h0000;
  logic        m_pf = 1'b0;
  bit          model_valid = 1'b0;
  logic [6:0]  segtab [16];

  typedef struct packed {
    logic [15:0]      word;
    logic             blz;
    logic [3:0][6:0]  segs;  // index = digit
    logic [3:0][3:0]  ans;
  } vec_t;

  vec_t vecs [6];

  bcd_display_scan #(.PRESCALE(P)) dut (
    .clk        (clk),
    .clr        (clr),
    .bcd_in     (bcd_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected outputs derived from edge count and active word
  task automatic check_model();
    int unsigned idx;
    logic [15:0] upper;
    logic [3:0]  d;
    bit          blanked;
    idx     = (n_edges / P) % 4;
    upper   = m_act >> (4 * idx);
    d       = upper[3:0];
    blanked = (blank_lz == 1'b1) && (idx != 0) && (upper == 16'h0000);
    chk("model_idx", 16'(digit_idx), 16'(idx));
    chk("model_seg", 16'(seg), blanked ? 16'h0000 : 16'(segtab[d]));
    chk("model_an", 16'(an), blanked ? 16'h0000 : 16'(1 << idx));
    chk("model_frame_done", 16'(frame_done),
        16'((n_edges > 0) && (n_edges % (4 * P) == 0)));
  endtask

  // One clock: capture inputs, advance model, sample 1 time unit after edge
  task automatic step();
    logic        c, l;
    logic [15:0] b;
    c = clr;
    l = load;
    b = bcd_in;
    @(posedge clk);
    if (c) begin
      n_edges     = 0;
      m_act       = 16'h0000;
      m_pnd       = 16'h0000;
      m_pf        = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      n_edges++;
      if ((n_edges % (4 * P) == 0) && m_pf) begin
        m_act = m_pnd;
        m_pf  = 1'b0;
      end
      if (l) begin
        m_pnd = b;
        m_pf  = 1'b1;
      end
    end
    #1;
    if (model_valid) check_model();
  endtask

  task automatic load_word(input logic [15:0] w);
    bcd_in = w;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int k;
    k = 0;
    while (frame_done !== 1'b1 && k < int'(8 * P)) begin
      step();
      k++;
    end
    chk(name, 16'(frame_done), 16'h0001);
  endtask

  initial begin
    segtab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    vecs[0] = '{16'h1907, 1'b0, {7'h06, 7'h6F, 7'h3F, 7'h07}, {4'h8, 4'h4, 4'h2, 4'h1}};
    vecs[1] = '{16'h0042, 1'b1, {7'h00, 7'h00, 7'h66, 7'h5B}, {4'h0, 4'h0, 4'h2, 4'h1}};
    vecs[2] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, {4'h0, 4'h0, 4'h0, 4'h1}};
    vecs[3] = '{16'h0402, 1'b1, {7'h00, 7'h66, 7'h3F, 7'h5B}, {4'h0, 4'h4, 4'h2, 4'h1}};
    vecs[4] = '{16'h00A5, 1'b1, {7'h00, 7'h00, 7'h40, 7'h6D}, {4'h0, 4'h0, 4'h2, 4'h1}};
    vecs[5] = '{16'h1907, 1'b1, {7'h06, 7'h6F, 7'h3F, 7'h07}, {4'h8, 4'h4, 4'h2, 4'h1}};

    // Reset for two cycles
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
    chk("rst_an", 16'(an), 16'h0001);
    chk("rst_seg", 16'(seg), 16'h003F);
    chk("rst_idx", 16'(digit_idx), 16'h0000);
    chk("rst_frame_done", 16'(frame_done), 16'h0000);

    // Scan timing after reset
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 4)  chk("scan_idx1", 16'(digit_idx), 16'h0001);
      if (k == 8)  chk("scan_idx2", 16'(digit_idx), 16'h0002);
      if (k == 12) chk("scan_idx3", 16'(digit_idx), 16'h0003);
      if (k == 15) chk("scan_fd_pre", 16'(frame_done), 16'h0000);
      if (k == 16) begin
        chk("scan_wrap_idx", 16'(digit_idx), 16'h0000);
        chk("scan_fd", 16'(frame_done), 16'h0001);
      end
      if (k == 17) chk("scan_fd_pulse", 16'(frame_done), 16'h0000);
    end

    // Vector table: load mid-frame, then check each digit of the next frame
    for (int v = 0; v < 6; v++) begin
      blank_lz = vecs[v].blz;
      wait_frame($sformatf("vec%0d_sync", v));
      repeat (5) step();
      load_word(vecs[v].word);
      wait_frame($sformatf("vec%0d_frame", v));
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("vec%0d_idx%0d", v, i), 16'(digit_idx), 16'(i));
        chk($sformatf("vec%0d_seg%0d", v, i), 16'(seg), 16'(vecs[v].segs[i]));
        chk($sformatf("vec%0d_an%0d", v, i), 16'(an), 16'(vecs[v].ans[i]));
        repeat (P) step();
      end
    end

    // Two loads in one frame: last one wins
    blank_lz = 1'b0;
    wait_frame("two_sync");
    repeat (3) step();
    load_word(16'h1111);
    repeat (2) step();
    load_word(16'h2222);
    wait_frame("two_frame");
    chk("two_last_wins", 16'(seg), 16'h005B);

    // Clear display to zero, then load 3333 on the boundary edge with 2222 pending
    repeat (3) step();
    load_word(16'h0000);
    wait_frame("bnd_zero");
    chk("bnd_zero_seg", 16'(seg), 16'h003F);
    repeat (3) step();
    load_word(16'h2222);
    begin
      int k;
      k = 0;
      while ((n_edges % (4 * P)) != (4 * P - 1) && k < int'(8 * P)) begin
        step();
        k++;
      end
    end
    load_word(16'h3333);
    chk("bnd_fd", 16'(frame_done), 16'h0001);
    chk("bnd_old_pending", 16'(seg), 16'h005B);
    step();
    wait_frame("bnd_next");
    chk("bnd_new_word", 16'(seg), 16'h004F);

    // Clear while a load is pending: pending word is discarded
    repeat (3) step();
    load_word(16'h9999);
    repeat (2) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_an", 16'(an), 16'h0001);
    chk("clr_seg", 16'(seg), 16'h003F);
    chk("clr_idx", 16'(digit_idx), 16'h0000);
    chk("clr_fd", 16'(frame_done), 16'h0000);
    for (int f = 0; f < 2; f++) begin
      wait_frame($sformatf("clr_frame%0d", f));
      chk($sformatf("clr_seg_frame%0d", f), 16'(seg), 16'h003F);
    end

    // Randomized loads, blanking toggles and occasional clears
    for (int r = 0; r < 3000; r++) begin
      load   = ($urandom_range(7) == 0);
      bcd_in = 16'($urandom);
      clr    = ($urandom_range(299) == 0);
      if ($urandom_range(15) == 0) blank_lz = ~blank_lz;
      step();
    end
    load = 1'b0;
    clr  = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

- Synchronous 4-digit multiplexed seven-segment display driver.
- Sits directly downstream of the decade (MOD-10) counter chain and consumes its packed BCD digits.
- Captures a 16-bit BCD word on a load strobe and commits it to the display only at a frame boundary, so digits never tear.
- Scans one digit at a time at a prescaled rate, with optional leading-zero blanking and a dash for invalid codes.

## Interface
- PRESCALE, 4, clock cycles each digit is displayed; legal range ≥1; prescale counter width is max(1, $clog2(PRESCALE)).
- clk  input  1  system clock, rising edge.
- clr  input  1  reset, synchronous, active-high.
- bcd_in  input  16  packed BCD; digit0 = bcd_in[3:0] (least significant), digit3 = bcd_in[15:12].
- load  input  1  capture bcd_in into the pending register this edge.
- blank_lz  input  1  enable leading-zero blanking (level, sampled combinationally).
- seg  output  7  segments {g,f,e,d,c,b,a}, seg[0]=a, active-high.
- an  output  4  one-hot digit enable, an[i] drives digit i, active-high.
- digit_idx  output  2  index of the currently scanned digit.
- frame_done  output  1  one-cycle pulse at start of each new frame.

## Operation
- State: prescale counter pc, digit index idx, active word act[15:0], pending word pnd[15:0], pending flag pf, frame_done register.
- Reset (clr=1 at edge): pc=0, idx=0, act=0, pnd=0, pf=0, frame_done=0; overrides load; pending data is discarded.
- Prescaler: tick = (pc == PRESCALE-1); on tick pc→0, else pc+1.
- On tick: idx→idx+1, wrapping 3→0.
- Frame boundary = tick with idx==3. At that edge: frame_done←1 (otherwise 0); if pf, act←pnd and pf←0.
- Load: load=1 at an edge sets pnd←bcd_in and pf←1. A later load before the boundary overwrites pnd (last write wins).
- Load coincident with boundary: act takes the old pnd (if pf was set); the new bcd_in goes to pnd and pf stays 1.
- seg, an and digit_idx are combinational decodes of registered idx and act (no extra latency); digit_idx = idx.
- Decode of d = act[4*idx+3 : 4*idx]:
  - 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07, 8→0x7F, 9→0x6F.
  - 10–15→0x40 (dash, g only).
- Leading-zero blanking, when blank_lz=1: digit i (i = 3, 2, 1) is blanked if it and every higher digit are 0. Blanked means seg=0 and an=0000.
  - Digit 0 is never blanked.
  - Invalid codes count as nonzero.
- Otherwise an = 1<<idx.

## Timing
- Reset values of outputs: digit_idx=0, an=4'b0001, seg=0x3F, frame_done=0.
- Each digit dwells exactly PRESCALE cycles; frame = 4·PRESCALE cycles.
- With cycle 0 = first edge after clr deasserts, idx changes at cycles PRESCALE, 2·PRESCALE, 3·PRESCALE.
- idx wraps to 0 at cycle 4·PRESCALE. frame_done is high during the first cycle of idx==0 of each new frame (not after reset).
- New act is visible in the same cycle frame_done is high.
- Load-to-display latency: 1 to 4·PRESCALE cycles.
- PRESCALE=1: idx advances every cycle; frame_done high every 4th cycle.

## Test plan
- clr for 2 cycles, PRESCALE=4, then run → an=0001, seg=0x3F, frame_done=0; idx=1, 2, 3 at cycles 4, 8, 12; idx=0 with frame_done=1 for one cycle at cycle 16.
- load 16'h1907 mid-frame, blank_lz=0 → display unchanged until frame_done. Then:
  - digit0 seg=0x07, digit1=0x3F, digit2=0x6F, digit3=0x06.
  - an one-hot in sequence.
- blank_lz=1, word 16'h0042 → digits 3, 2 show an=0000 and seg=0; digit1=0x66, digit0=0x5B.
  - 16'h0000 → only digit0 lit, 0x3F.
  - 16'h0402 → digit1 shows 0x3F (not blanked).
- blank_lz=1, word 16'h00A5 → digit1 seg=0x40 and lit; digit2/digit3 blanked; digit0=0x6D.
- Two loads in one frame:
  - 16'h1111 then 16'h2222 → only 2222 is ever displayed.
  - load 16'h3333 on a boundary edge while 2222 is pending → 2222 appears now, 3333 at the next boundary.
- load 16'h9999, then clr before the boundary → reset output values; the display stays 0000 through following frames (pending discarded).
